// File: rtl/opc5_memio_pkg.sv
// Shared definitions for the OPC5 memory/I-O responder.
// Build option: OPC5_MEMIO_TIMER_EN enables the free-running timer.
package opc5_memio_pkg;

    localparam logic [3:0] OFF_UART   = 4'd0;
    localparam logic [3:0] OFF_STATUS = 4'd1;
    localparam logic [3:0] OFF_TCNT   = 4'd2;
    localparam logic [3:0] OFF_TCMP   = 4'd3;

    localparam int ST_FULL   = 0;
    localparam int ST_BUSY   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_TMATCH = 3;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

endpackage

// File: rtl/opc5_uart_tx.sv
// UART transmitter: byte FIFO, baud counter, 8N1 shifter and frame FSM.
// Build option: none (timer lives in opc5_memio under OPC5_MEMIO_TIMER_EN).
module opc5_uart_tx
    import opc5_memio_pkg::*;
#(
    parameter int FIFO_AW  = 2,
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       push,
    input  logic [7:0] wdata,
    output logic       full,
    output logic [7:0] count,
    output logic       busy,
    output logic       drop,
    output logic       txd
);

    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(2**FIFO_AW);
    localparam logic [BW-1:0] LAST = BW'(BAUD_DIV-1);

    logic [7:0]         fifo [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   cnt;
    uart_state_t        state, state_nx;
    logic [BW-1:0]      baud, baud_nx;
    logic [2:0]         bit_idx, bit_nx;
    logic [7:0]         shreg, sh_nx;
    logic               pop, accept, tick, pending;

    assign full    = (cnt == DEPTH);
    assign pending = (cnt != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign accept  = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign count   = 8'(cnt);
    assign busy    = pending || (state != U_IDLE);
    assign tick    = (baud == LAST);

    always_ff @(posedge clk) begin
        if (accept)
            fifo[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            state   <= U_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= 8'hFF;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !accept)
                cnt <= cnt - 1'b1;
            state   <= state_nx;
            baud    <= baud_nx;
            bit_idx <= bit_nx;
            shreg   <= sh_nx;
        end
    end

    always_comb begin
        state_nx = state;
        baud_nx  = baud;
        bit_nx   = bit_idx;
        sh_nx    = shreg;
        pop      = 1'b0;
        unique case (state)
            U_IDLE: begin
                if (pending) begin
                    pop      = 1'b1;
                    sh_nx    = fifo[rd_ptr];
                    baud_nx  = '0;
                    state_nx = U_START;
                end
            end
            U_START: begin
                baud_nx = tick ? '0 : baud + 1'b1;
                if (tick) begin
                    bit_nx   = '0;
                    state_nx = U_DATA;
                end
            end
            U_DATA: begin
                baud_nx = tick ? '0 : baud + 1'b1;
                if (tick) begin
                    sh_nx  = {1'b1, shreg[7:1]};
                    bit_nx = bit_idx + 1'b1;
                    if (bit_idx == 3'd7)
                        state_nx = U_STOP;
                end
            end
            U_STOP: begin
                baud_nx = tick ? '0 : baud + 1'b1;
                if (tick) begin
                    if (pending) begin
                        pop      = 1'b1;
                        sh_nx    = fifo[rd_ptr];
                        state_nx = U_START;
                    end else begin
                        state_nx = U_IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        txd = 1'b1;
        if (state == U_START)
            txd = 1'b0;
        else if (state == U_DATA)
            txd = shreg[0];
    end

endmodule

// File: rtl/opc5_memio.sv
// OPC5 bus responder: aliased RAM, UART and STATUS registers, optional timer.
// Build option: define OPC5_MEMIO_TIMER_EN for TIMER_COUNT/TIMER_CMP and tmatch.
module opc5_memio
    import opc5_memio_pkg::*;
#(
    parameter int          RAM_AW   = 11,
    parameter logic [15:0] IO_BASE  = 16'hFE00,
    parameter int          FIFO_AW  = 2,
    parameter int          BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] address,
    inout  wire  [15:0] data,
    input  logic        rnw,
    output logic        txd,
    output logic        tx_busy
);

    logic [15:0] ram [2**RAM_AW];
    logic [15:0] rdata, io_rdata;
    logic [3:0]  off;
    logic        io_sel, wr, push, st_wr;
    logic        full, drop, ovf, tmatch;
    logic [7:0]  count;

    assign io_sel = (address[15:4] == IO_BASE[15:4]);
    assign off    = address[3:0];
    assign wr     = !rnw;
    assign push   = wr && io_sel && (off == OFF_UART);
    assign st_wr  = wr && io_sel && (off == OFF_STATUS);

    opc5_uart_tx #(
        .FIFO_AW  (FIFO_AW),
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk     (clk),
        .reset_b (reset_b),
        .push    (push),
        .wdata   (data[7:0]),
        .full    (full),
        .count   (count),
        .busy    (tx_busy),
        .drop    (drop),
        .txd     (txd)
    );

    always_ff @(posedge clk) begin
        if (wr && !io_sel)
            ram[address[RAM_AW-1:0]] <= data;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
        else if (st_wr)
            ovf <= 1'b0;
    end

`ifdef OPC5_MEMIO_TIMER_EN
    logic [15:0] tcnt, tcmp;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tcnt   <= '0;
            tcmp   <= 16'hFFFF;
            tmatch <= 1'b0;
        end else begin
            tcnt <= (wr && io_sel && off == OFF_TCNT) ? data : tcnt + 1'b1;
            if (wr && io_sel && off == OFF_TCMP)
                tcmp <= data;
            // Set takes priority over a STATUS-write clear
            if (tcnt == tcmp)
                tmatch <= 1'b1;
            else if (st_wr)
                tmatch <= 1'b0;
        end
    end
`else
    assign tmatch = 1'b0;
`endif

    always_comb begin
        io_rdata = '0;
        case (off)
            OFF_STATUS:
                io_rdata = {count, 4'b0, tmatch, ovf, tx_busy, full};
`ifdef OPC5_MEMIO_TIMER_EN
            OFF_TCNT: io_rdata = tcnt;
            OFF_TCMP: io_rdata = tcmp;
`endif
            default:  io_rdata = '0;
        endcase
    end

    assign rdata = io_sel ? io_rdata : ram[address[RAM_AW-1:0]];
    assign data  = rnw ? rdata : {16{1'bz}};

endmodule

// File: tb/tb_opc5_memio.sv
// Directed self-checking bench for opc5_memio (BAUD_DIV=4, FIFO_AW=2).
// Build option: OPC5_MEMIO_TIMER_EN selects timer-on expectations.
module tb_opc5_memio;

    logic        clk = 1'b0;
    logic        reset_b = 1'b1;
    logic [15:0] address = '0;
    logic        rnw = 1'b1;
    logic        drv_en = 1'b0;
    logic [15:0] drv_val = '0;
    wire  [15:0] data;
    logic        txd, tx_busy;
    int          total = 0;
    int          bad = 0;

    localparam logic [15:0] A_UART = 16'hFE00;
    localparam logic [15:0] A_STAT = 16'hFE01;
    localparam logic [15:0] A_TCNT = 16'hFE02;
    localparam logic [15:0] A_TCMP = 16'hFE03;

    assign data = drv_en ? drv_val : {16{1'bz}};

    always #5 clk = ~clk;

    opc5_memio #(
        .RAM_AW   (11),
        .IO_BASE  (16'hFE00),
        .FIFO_AW  (2),
        .BAUD_DIV (4)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .address (address),
        .data    (data),
        .rnw     (rnw),
        .txd     (txd),
        .tx_busy (tx_busy)
    );

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        drv_val = d;
        drv_en  = 1'b1;
        rnw     = 1'b0;
        @(posedge clk);
        #1;
        rnw    = 1'b1;
        drv_en = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        @(negedge clk);
        address = a;
        rnw     = 1'b1;
        #1;
        v = data;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle timeout busy=%b want 0", name, tx_busy);
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        #2 reset_b = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (txd !== 1'b1 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_out txd=%b busy=%b want 1 0", txd, tx_busy);
        end
        reset_b = 1'b1;
        rd(A_STAT, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL reset_status got %h want 0000", v);
        end
    endtask

    task automatic test_ram();
        logic [15:0] v;
        wr(16'h0010, 16'hBEEF);
        rd(16'h0010, v);
        total++;
        if (v !== 16'hBEEF) begin
            bad++;
            $display("FAIL ram_rd got %h want BEEF", v);
        end
        rd(16'h0810, v);
        total++;
        if (v !== 16'hBEEF) begin
            bad++;
            $display("FAIL ram_alias got %h want BEEF", v);
        end
        wr(16'h0811, 16'h1234);
        rd(16'h0011, v);
        total++;
        if (v !== 16'h1234) begin
            bad++;
            $display("FAIL ram_alias2 got %h want 1234", v);
        end
        rd(16'hFE07, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL io_unused got %h want 0000", v);
        end
        rd(A_UART, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL uart_rd got %h want 0000", v);
        end
    endtask

    task automatic test_frame();
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        wr(A_UART, 16'h00A5);
        @(negedge clk);
        total++;
        if (tx_busy !== 1'b1 || txd !== 1'b1) begin
            bad++;
            $display("FAIL frame_pre busy=%b txd=%b want 1 1", tx_busy, txd);
        end
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                total++;
                if (txd !== fr[i]) begin
                    bad++;
                    $display("FAIL frame_bit%0d_%0d txd=%b want %b", i, j, txd, fr[i]);
                end
            end
        end
        @(negedge clk);
        total++;
        if (tx_busy !== 1'b0 || txd !== 1'b1) begin
            bad++;
            $display("FAIL frame_end busy=%b txd=%b want 0 1", tx_busy, txd);
        end
    endtask

    task automatic test_fifo_ovf();
        logic [15:0] v;
        for (int i = 0; i < 6; i++)
            wr(A_UART, 16'(8'h11 + i));
        rd(A_STAT, v);
        total++;
        if (v !== 16'h0407) begin
            bad++;
            $display("FAIL ovf_set got %h want 0407", v);
        end
        wr(A_STAT, 16'h0000);
        rd(A_STAT, v);
        total++;
        if (v !== 16'h0403) begin
            bad++;
            $display("FAIL ovf_clear got %h want 0403", v);
        end
        wait_idle("ovf_drain");
    endtask

    task automatic test_back_to_back();
        logic [9:0] fr;
        fr = {1'b1, 8'h01, 1'b0};
        wr(A_UART, 16'h0001);
        wr(A_UART, 16'h0080);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i > 0 || j > 0)
                    @(negedge clk);
                else
                    @(negedge clk);
                total++;
                if (txd !== fr[i]) begin
                    bad++;
                    $display("FAIL b2b_bit%0d_%0d txd=%b want %b", i, j, txd, fr[i]);
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            total++;
            if (txd !== 1'b0 || tx_busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_start2_%0d txd=%b busy=%b want 0 1", j, txd, tx_busy);
            end
        end
        wait_idle("b2b_drain");
    endtask

    task automatic test_timer();
        logic [15:0] v;
        logic [15:0] exp [4];
`ifdef OPC5_MEMIO_TIMER_EN
        exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        wr(A_TCMP, 16'h0001);
        rd(A_TCMP, v);
        total++;
        if (v !== 16'h0001) begin
            bad++;
            $display("FAIL tcmp_rd got %h want 0001", v);
        end
        wr(A_STAT, 16'h0000);
        wr(A_TCNT, 16'hFFFE);
        for (int i = 0; i < 4; i++) begin
            rd(A_TCNT, v);
            total++;
            if (v !== exp[i]) begin
                bad++;
                $display("FAIL tcnt_%0d got %h want %h", i, v, exp[i]);
            end
        end
        rd(A_STAT, v);
        total++;
        if (v !== 16'h0008) begin
            bad++;
            $display("FAIL tmatch_set got %h want 0008", v);
        end
        wr(A_STAT, 16'h0000);
        rd(A_STAT, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL tmatch_clr got %h want 0000", v);
        end
`else
        exp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        wr(A_TCNT, 16'h0005);
        wr(A_TCMP, 16'h0005);
        rd(A_TCNT, v);
        total++;
        if (v !== exp[0]) begin
            bad++;
            $display("FAIL tcnt_off got %h want 0000", v);
        end
        rd(A_TCMP, v);
        total++;
        if (v !== exp[1]) begin
            bad++;
            $display("FAIL tcmp_off got %h want 0000", v);
        end
        repeat (8) @(negedge clk);
        rd(A_STAT, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL tmatch_off got %h want 0000", v);
        end
`endif
    endtask

    task automatic test_reset_abort();
        logic [15:0] v;
        wr(A_UART, 16'h00C3);
        wr(A_UART, 16'h003C);
        wr(A_UART, 16'h0055);
        repeat (12) @(negedge clk);
        total++;
        if (tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre busy=%b want 1", tx_busy);
        end
        reset_b = 1'b0;
        #1;
        total++;
        if (txd !== 1'b1 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_now txd=%b busy=%b want 1 0", txd, tx_busy);
        end
        rd(A_STAT, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL abort_status got %h want 0000", v);
        end
        @(negedge clk);
        reset_b = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (txd !== 1'b1 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_after txd=%b busy=%b want 1 0", txd, tx_busy);
        end
        @(negedge clk);
        address = 16'h0020;
        drv_val = 16'h5A5A;
        drv_en  = 1'b1;
        rnw     = 1'b0;
        #1;
        total++;
        if (data !== 16'h5A5A) begin
            bad++;
            $display("FAIL bus_release got %h want 5A5A", data);
        end
        @(posedge clk);
        #1;
        rnw    = 1'b1;
        drv_en = 1'b0;
        rd(16'h0020, v);
        total++;
        if (v !== 16'h5A5A) begin
            bad++;
            $display("FAIL bus_wr got %h want 5A5A", v);
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_frame();
        test_fifo_ovf();
        test_back_to_back();
        test_timer();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
